config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 129 ++++++++++++
 tb/tb_config_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Configuration stream loader: parses 5-byte frames (tile addr + LE word)
// and broadcasts each word with a one-hot per-tile write strobe.
module config_loader #(
  parameter int NUM_TILES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam logic [8:0] NT = 9'(NUM_TILES);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] cdat_q, cdat_d;
  logic        err_q, err_d;
  logic [15:0] fc_q, fc_d;

  logic acc;
  logic wr;
  logic addr_ok;

  assign in_ready    = (state_q == IDLE) || (state_q == DATA);
  assign acc         = in_valid && in_ready;
  assign wr          = (state_q == WRITE);
  assign addr_ok     = ({1'b0, addr_q} < NT);
  assign config_data = wr ? asm_q : cdat_q;
  assign done        = (state_q == DONE);
  assign error       = err_q;
  assign frame_count = fc_q;

  // One-hot strobe only in a WRITE cycle whose latched address is in range
  always_comb begin
    config_en = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (wr && addr_ok && (addr_q == 8'(i))) begin
        config_en[i] = 1'b1;
      end
    end
  end

  // Next-state: header decode, byte assembly, write bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    cdat_d  = cdat_q;
    err_d   = err_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (in_data == 8'hFF) begin
            state_d = DONE;
          end else begin
            addr_d  = in_data;
            cnt_d   = 2'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          asm_d[{cnt_q, 3'b000} +: 8] = in_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (addr_ok) begin
          cdat_d = asm_q;
          if (fc_q != 16'hFFFF) begin
            fc_d = fc_q + 16'd1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 8'd0;
      asm_q   <= 32'd0;
      cdat_q  <= 32'd0;
      err_q   <= 1'b0;
      fc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      cdat_q  <= cdat_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a scoreboard of expected
// config_en/config_data write pulses.
module tb_config_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        done;
  logic        error;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] en;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];

  config_loader #(.NUM_TILES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .config_data (config_data),
    .config_en   (config_en),
    .done        (done),
    .error       (error),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] en, input logic [31:0] d);
    exp_t e;
    e.en = en;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns just after the rising edge that transferred the byte
  task automatic send(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("ready_wait", 32'(w), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [31:0] d,
                       input int gap);
    send(a, gap);
    send(d[7:0], gap);
    send(d[15:8], gap);
    send(d[23:16], gap);
    send(d[31:24], gap);
  endtask

  // Monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && config_en != 16'd0) begin
      chk("en_onehot", 32'($onehot0(config_en)), 32'd1);
      chk("en_ready_low", 32'(in_ready), 32'd0);
      if (sb.size() == 0) begin
        chk("en_unexpected", 32'(config_en), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("en_value", 32'(config_en), 32'(e.en));
        chk("en_data", config_data, e.d);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_data", config_data, 32'd0);
    chk("rst_en", 32'(config_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);

    // Single write, back-to-back bytes, with latency checks
    push(16'h0008, 32'h12345678);
    frame(8'h03, 32'h12345678, 0);
    @(negedge clk);
    chk("lat_en", 32'(config_en), 32'h0008);
    chk("lat_ready0", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_ready1", 32'(in_ready), 32'd1);
    chk("lat_en_off", 32'(config_en), 32'd0);
    chk("hold_data", config_data, 32'h12345678);
    chk("single_fc", 32'(frame_count), 32'd1);

    // Stalled frame
    do_reset(1);
    push(16'h0001, 32'hDEADBEEF);
    frame(8'h00, 32'hDEADBEEF, 2);
    repeat (3) @(negedge clk);
    chk("stall_fc", 32'(frame_count), 32'd1);

    // Invalid address then a valid frame
    do_reset(1);
    frame(8'h20, 32'h04030201, 0);
    repeat (2) @(negedge clk);
    chk("inv_error", 32'(error), 32'd1);
    chk("inv_fc", 32'(frame_count), 32'd0);
    push(16'h0020, 32'hDDCCBBAA);
    frame(8'h05, 32'hDDCCBBAA, 0);
    repeat (2) @(negedge clk);
    chk("inv2_fc", 32'(frame_count), 32'd1);
    chk("inv2_error", 32'(error), 32'd1);

    // Address boundaries: 15 valid, 16 invalid
    do_reset(1);
    push(16'h8000, 32'hCAFEF00D);
    frame(8'h0F, 32'hCAFEF00D, 0);
    frame(8'h10, 32'h55555555, 1);
    repeat (2) @(negedge clk);
    chk("bnd_fc", 32'(frame_count), 32'd1);
    chk("bnd_error", 32'(error), 32'd1);
    chk("bnd_hold", config_data, 32'hCAFEF00D);

    // Reset mid-frame discards the partial frame
    do_reset(1);
    send(8'h02, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    do_reset(1);
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_data", config_data, 32'd0);
    push(16'h0004, 32'h00000001);
    frame(8'h02, 32'h00000001, 0);
    repeat (2) @(negedge clk);
    chk("mid_fc", 32'(frame_count), 32'd1);

    // 8'hFF as data is ordinary data
    do_reset(1);
    push(16'h0002, 32'hFFFFFFFF);
    frame(8'h01, 32'hFFFFFFFF, 0);
    repeat (2) @(negedge clk);
    chk("ffdata_done", 32'(done), 32'd0);
    chk("ffdata_fc", 32'(frame_count), 32'd1);

    // End of stream, later bytes ignored
    do_reset(1);
    push(16'h0002, 32'h44332211);
    frame(8'h01, 32'h44332211, 0);
    send(8'hFF, 0);
    @(negedge clk);
    chk("eos_done", 32'(done), 32'd1);
    chk("eos_ready", 32'(in_ready), 32'd0);
    in_data  = 8'h05;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    chk("eos_done_hold", 32'(done), 32'd1);
    chk("eos_ready_hold", 32'(in_ready), 32'd0);
    chk("eos_fc", 32'(frame_count), 32'd1);
    chk("eos_error", 32'(error), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
